// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs symbolic MIPS instructions into 32-bit words
// and streams them sequentially into instruction memory from word 0.
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op_sel,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  full,
    output logic                  err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FULL
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;

    logic [31:0]           enc_word;
    logic                  enc_legal;
    logic                  xfer;
    logic [ADDR_WIDTH:0]   count_inc;

    assign in_ready   = (state_q == IDLE) && !clr;
    assign xfer       = in_valid && in_ready;
    assign count_inc  = count_q + 1'b1;

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign full       = full_q;
    assign err        = err_q;

    // Pack the symbolic fields into the word the control path decodes.
    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b1;
        case (op_sel)
            4'd0: enc_word = {6'd0, rs, rt, rd, 5'd0, 6'h20};
            4'd1: enc_word = {6'd0, rs, rt, rd, 5'd0, 6'h22};
            4'd2: enc_word = {6'd0, rs, rt, rd, 5'd0, 6'h24};
            4'd3: enc_word = {6'd0, rs, rt, rd, 5'd0, 6'h25};
            4'd4: enc_word = {6'd0, rs, rt, rd, 5'd0, 6'h2A};
            4'd5: enc_word = {6'd8, rs, rt, imm};
            4'd6: enc_word = {6'd35, rs, rt, imm};
            4'd7: enc_word = {6'd43, rs, rt, imm};
            4'd8: enc_word = {6'd4, rs, rt, imm};
            4'd9: enc_word = {6'd2, target};
            default: enc_legal = 1'b0;
        endcase
    end

    // Next-state logic: accept in IDLE, strobe in WRITE, park in FULL.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        full_d   = full_q;
        err_d    = 1'b0;
        if (clr) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (enc_legal) begin
                            addr_d  = wr_ptr_q;
                            wdata_d = enc_word;
                            we_d    = 1'b1;
                            state_d = WRITE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_inc;
                    if (count_inc == DEPTH_CNT) begin
                        state_d = FULL;
                        full_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            full_q   <= full_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed and random stimulus against a
// transaction-level model of the encoder/loader.
module tb_instr_encoder_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst, clr, in_valid, in_ready;
    logic [3:0]    op_sel;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          full, err;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit          m_busy = 0;
    bit          m_full = 0;
    int          m_cnt  = 0;
    bit          m_we   = 0;
    bit          m_err  = 0;
    int          m_addr = 0;
    logic [31:0] m_wdata = 0;
    bit          armed  = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .word_count(word_count),
        .full(full), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_enc(input int op, input int s,
            input int t, input int d, input int im, input int tg);
        int fn[5];
        int opc[4];
        fn  = '{'h20, 'h22, 'h24, 'h25, 'h2A};
        opc = '{8, 35, 43, 4};
        if (op < 5)
            return 32'(s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + fn[op]);
        if (op < 9)
            return 32'(opc[op-5] * (1 << 26) + s * (1 << 21)
                       + t * (1 << 16) + im);
        return 32'(2 * (1 << 26) + tg);
    endfunction

    task automatic step(input bit r, input bit c, input bit v,
                        input int op, input int s, input int t,
                        input int d, input int im, input int tg);
        bit rdy;
        @(negedge clk);
        rst = r; clr = c; in_valid = v;
        op_sel = 4'(op); rs = 5'(s); rt = 5'(t); rd = 5'(d);
        imm = 16'(im); target = 26'(tg);
        #1;
        rdy = !m_busy && !m_full && !c;
        if (armed) check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        @(posedge clk);
        m_we = 0;
        m_err = 0;
        if (r) begin
            m_busy = 0; m_full = 0; m_cnt = 0;
            m_addr = 0; m_wdata = 0;
        end else if (m_busy) begin
            m_busy = 0;
            if (c) m_cnt = 0;
            else m_cnt++;
            m_full = !c && (m_cnt == DEPTH);
        end else if (c) begin
            m_cnt = 0; m_full = 0;
        end else if (v && rdy) begin
            if (op <= 9) begin
                m_we = 1; m_busy = 1; m_addr = m_cnt;
                m_wdata = model_enc(op, s, t, d, im, tg);
            end else begin
                m_err = 1;
            end
        end
        #1;
        armed = 1;
        check("imem_we", {31'd0, imem_we}, {31'd0, m_we});
        check("imem_addr", 32'(imem_addr), 32'(m_addr));
        check("imem_wdata", imem_wdata, m_wdata);
        check("word_count", 32'(word_count), 32'(m_cnt));
        check("full", {31'd0, full}, {31'd0, m_full});
        check("err", {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; clr = 0; in_valid = 0; op_sel = 0;
        rs = 0; rt = 0; rd = 0; imm = 0; target = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // ADD r3 = r1 + r2
        step(0, 0, 1, 0, 1, 2, 3, 0, 0);
        check("add_word", imem_wdata, 32'h00221820);
        check("add_addr", 32'(imem_addr), 32'd0);
        idle();
        check("add_cnt", 32'(word_count), 32'd1);
        // LW, BEQ, J back to back with valid held
        step(0, 0, 1, 6, 16, 8, 0, 'h0004, 0);
        check("lw_word", imem_wdata, 32'h8E080004);
        step(0, 0, 1, 6, 16, 8, 0, 'h0004, 0);
        step(0, 0, 1, 8, 1, 2, 0, 'hFFFF, 0);
        check("beq_word", imem_wdata, 32'h1022FFFF);
        step(0, 0, 1, 8, 1, 2, 0, 'hFFFF, 0);
        step(0, 0, 1, 9, 0, 0, 0, 0, 'h10);
        check("j_word", imem_wdata, 32'h08000010);
        step(0, 0, 1, 9, 0, 0, 0, 0, 'h10);
        // now full: held valid must not write
        check("full_set", {31'd0, full}, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 5, 1, 1, 0, 7, 0);
        step(0, 1, 1, 5, 1, 1, 0, 7, 0);
        // illegal op consumed, then legal goes to addr 0
        step(0, 0, 1, 15, 0, 0, 0, 0, 0);
        check("err_pulse", {31'd0, err}, 32'd1);
        idle();
        step(0, 0, 1, 5, 3, 4, 0, 'h1234, 0);
        check("after_err_addr", 32'(imem_addr), 32'd0);
        idle();
        // clr during the write of word 2
        step(0, 0, 1, 1, 5, 6, 7, 0, 0);
        idle();
        step(0, 0, 1, 2, 5, 6, 7, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("clr_wr_cnt", 32'(word_count), 32'd0);
        step(0, 0, 1, 3, 9, 10, 11, 0, 0);
        check("clr_wr_addr", 32'(imem_addr), 32'd0);
        // reset with valid and clr
        step(1, 1, 1, 4, 1, 1, 1, 0, 0);
        idle();
        // random traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0,
                 $urandom_range(3) != 0, int'($urandom_range(15)),
                 int'($urandom_range(31)), int'($urandom_range(31)),
                 int'($urandom_range(31)), int'($urandom_range(65535)),
                 int'($urandom & 32'h03FF_FFFF));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
